titan_if_stage: RTL and testbench

- Instruction-fetch stage of the Titan 5-stage RV32 pipeline.
- Owns the PC and drives the instruction bus with a single-outstanding request/ack handshake.
- Applies redirects from the ID stage (branch, jump) and from the exception unit (trap target).
- Loads the IF/ID pipeline register that feeds the decode stage: pc, instruction and fetch-exception flags.

---
 rtl/titan_if_stage_pkg.sv | 18 +
 rtl/titan_if_stage_if.sv | 21 ++
 rtl/titan_if_stage_ifid.sv | 34 +++
 rtl/titan_if_stage.sv | 113 +++++++++++
 tb/tb_titan_if_stage.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/titan_if_stage_pkg.sv
// Shared constants and types for the Titan instruction-fetch stage.
package titan_if_stage_pkg;

    localparam logic [31:0] NOP_INSTR          = 32'h0000_0013;
    localparam logic [31:0] RESET_ADDR_DEFAULT = 32'h8000_0000;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        mis;
        logic        err;
    } ifid_t;

endpackage

// File: rtl/titan_if_stage_if.sv
// Instruction bus: single-outstanding request with ack/err completion.
interface titan_if_stage_if;

    logic [31:0] iport_address_o;
    logic        iport_cyc_o;
    logic        iport_stb_o;
    logic [31:0] iport_data_i;
    logic        iport_ack_i;
    logic        iport_err_i;

    modport master (
        output iport_address_o, iport_cyc_o, iport_stb_o,
        input  iport_data_i, iport_ack_i, iport_err_i
    );

    modport slave (
        input  iport_address_o, iport_cyc_o, iport_stb_o,
        output iport_data_i, iport_ack_i, iport_err_i
    );

endinterface

// File: rtl/titan_if_stage_ifid.sv
// IF/ID pipeline register; a bubble keeps the pc and clears instruction and flags.
module titan_ifid_register
    import titan_if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = RESET_ADDR_DEFAULT,
    parameter logic [31:0] NOP        = NOP_INSTR
) (
    input  logic  i_clk,
    input  logic  i_rst,
    input  logic  i_stall,
    input  logic  i_flush,
    input  ifid_t i_d,
    output ifid_t o_q
);

    ifid_t r_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q <= '{RESET_ADDR, NOP, 1'b0, 1'b0};
        end else if (!i_stall) begin
            if (i_flush) begin
                r_q.instr <= NOP;
                r_q.mis   <= 1'b0;
                r_q.err   <= 1'b0;
            end else begin
                r_q <= i_d;
            end
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/titan_if_stage.sv
// Titan IF stage: PC ownership, redirect priority, bus fetch FSM and skid buffer.
module titan_if_stage #(
    parameter logic [31:0] RESET_ADDR = titan_if_stage_pkg::RESET_ADDR_DEFAULT,
    parameter logic [31:0] NOP_INSTR  = titan_if_stage_pkg::NOP_INSTR
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    if_stall_i,
    input  logic                    if_flush_i,
    input  logic [31:0]             pc_branch_address_i,
    input  logic                    take_branch_i,
    input  logic [31:0]             pc_jump_address_i,
    input  logic                    take_jump_i,
    input  logic [31:0]             exc_pc_i,
    input  logic                    exc_redirect_i,
    titan_if_stage_if.master        iport,
    output logic                    if_busy_o,
    output logic [31:0]             id_pc_o,
    output logic [31:0]             id_instruction_o,
    output logic                    id_exc_address_if_o,
    output logic                    id_bus_access_fault_o
);
    import titan_if_stage_pkg::*;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_kill_addr;
    logic        r_kill;
    ifid_t       r_buf;

    logic        w_mis, w_resp, w_bus, w_fetched, w_redir, w_avail, w_bubble;
    logic [31:0] w_target;
    ifid_t       w_fetch_d, w_ifid_d, w_ifid_q;

    assign w_mis     = |r_pc[1:0];
    assign w_resp    = iport.iport_ack_i | iport.iport_err_i;
    // A killed request keeps the bus up even if the redirect target is misaligned.
    assign w_bus     = (r_state == S_REQ) && (r_kill || !w_mis);
    assign w_fetched = (r_state == S_REQ) && !r_kill && (w_mis || w_resp);
    assign w_redir   = exc_redirect_i || (!if_stall_i && (take_jump_i || take_branch_i));
    assign w_avail   = w_fetched || (r_state == S_HOLD);
    assign w_bubble  = if_flush_i || w_redir || !w_avail;
    assign w_ifid_d  = (r_state == S_HOLD) ? r_buf : w_fetch_d;

    always_comb begin
        w_target = pc_branch_address_i;
        if (exc_redirect_i)   w_target = exc_pc_i;
        else if (take_jump_i) w_target = pc_jump_address_i;
    end

    always_comb begin
        w_fetch_d.pc    = r_pc;
        w_fetch_d.mis   = w_mis;
        w_fetch_d.err   = !w_mis && iport.iport_err_i;
        w_fetch_d.instr = (w_mis || iport.iport_err_i) ? NOP_INSTR : iport.iport_data_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_ADDR;
            r_kill      <= 1'b0;
            r_kill_addr <= RESET_ADDR;
            r_buf       <= '{RESET_ADDR, NOP_INSTR, 1'b0, 1'b0};
        end else begin
            if (w_redir)        r_pc <= w_target;
            else if (w_fetched) r_pc <= r_pc + 32'd4;

            // The old request's address stays on the bus until its response drains.
            if (w_bus && !w_resp && w_redir) begin
                r_kill <= 1'b1;
                if (!r_kill) r_kill_addr <= r_pc;
            end else if (w_bus && w_resp) begin
                r_kill <= 1'b0;
            end

            case (r_state)
                S_IDLE: r_state <= S_REQ;
                S_REQ: begin
                    if (w_fetched && if_stall_i && !w_redir) begin
                        r_state <= S_HOLD;
                        r_buf   <= w_fetch_d;
                    end
                end
                S_HOLD: if (w_redir || !if_stall_i) r_state <= S_REQ;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    titan_ifid_register #(
        .RESET_ADDR (RESET_ADDR),
        .NOP        (NOP_INSTR)
    ) u_ifid (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_stall (if_stall_i),
        .i_flush (w_bubble),
        .i_d     (w_ifid_d),
        .o_q     (w_ifid_q)
    );

    assign iport.iport_address_o = r_kill ? r_kill_addr : r_pc;
    assign iport.iport_cyc_o     = w_bus;
    assign iport.iport_stb_o     = w_bus;
    assign if_busy_o             = w_bus && !w_resp;

    assign id_pc_o               = w_ifid_q.pc;
    assign id_instruction_o      = w_ifid_q.instr;
    assign id_exc_address_if_o   = w_ifid_q.mis;
    assign id_bus_access_fault_o = w_ifid_q.err;

endmodule

// File: tb/tb_titan_if_stage.sv
// Bench for titan_if_stage: directed vector table, corner sequences, random fetch stream.
module tb_titan_if_stage;
    import titan_if_stage_pkg::*;

    localparam logic [31:0] RA  = 32'h8000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk, rst, stall, flush, tb, tj, exc;
    logic [31:0] br_a, jp_a, exc_a;
    logic        busy, id_mis, id_flt;
    logic [31:0] id_pc, id_instr;

    titan_if_stage_if bus ();

    titan_if_stage #(.RESET_ADDR(RA), .NOP_INSTR(NOP)) dut (
        .clk_i(clk), .rst_i(rst), .if_stall_i(stall), .if_flush_i(flush),
        .pc_branch_address_i(br_a), .take_branch_i(tb),
        .pc_jump_address_i(jp_a), .take_jump_i(tj),
        .exc_pc_i(exc_a), .exc_redirect_i(exc), .iport(bus),
        .if_busy_o(busy), .id_pc_o(id_pc), .id_instruction_o(id_instr),
        .id_exc_address_if_o(id_mis), .id_bus_access_fault_o(id_flt)
    );

    initial begin clk = 0; forever #5 clk = ~clk; end

    typedef struct {
        logic ack; logic stall; logic exp_cyc;
        logic [31:0] exp_addr; logic [31:0] exp_pc; logic [31:0] exp_instr;
    } vec_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; logic flt; } del_t;

    vec_t tv [9];
    del_t q [$];
    int   n_chk = 0, n_pass = 0, ndel = 0;
    logic have_last;
    logic [31:0] last_pc, p_pc, p_instr;

    task automatic tick(); @(posedge clk); #1; endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic run_vec(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            bus.iport_ack_i  = tv[i].ack;
            bus.iport_data_i = bus.iport_address_o;
            stall            = tv[i].stall;
            tick();
            chk($sformatf("vec%0d_cyc", i), bus.iport_cyc_o, tv[i].exp_cyc);
            if (tv[i].exp_cyc) chk($sformatf("vec%0d_addr", i), bus.iport_address_o, tv[i].exp_addr);
            chk($sformatf("vec%0d_idpc", i), id_pc, tv[i].exp_pc);
            chk($sformatf("vec%0d_instr", i), id_instr, tv[i].exp_instr);
        end
    endtask

    // Scoreboard: every accepted response must reach IF/ID once, in order.
    task automatic observe(input logic was_stall);
        del_t d;
        if (was_stall) begin
            chk("hold_pc", id_pc, p_pc);
            chk("hold_instr", id_instr, p_instr);
        end else if ((id_instr != NOP || id_flt) && (!have_last || id_pc != last_pc)) begin
            if (q.size() == 0) begin
                n_chk++;
                $display("FAIL spurious_delivery: got pc %h expected none", id_pc);
            end else begin
                d = q.pop_front();
                chk("del_pc", id_pc, d.pc);
                chk("del_instr", id_instr, d.instr);
                chk("del_flt", id_flt, d.flt);
                chk("del_mis", id_mis, 1'b0);
                ndel++;
            end
            have_last = 1'b1;
            last_pc   = id_pc;
        end
    endtask

    initial begin
        logic        req_act, e, st;
        int          lat;
        logic [31:0] req_addr, exp_fa;
        del_t        d;

        rst = 0; stall = 0; flush = 0; tb = 0; tj = 0; exc = 0;
        br_a = 0; jp_a = 0; exc_a = 0;
        bus.iport_ack_i = 0; bus.iport_err_i = 0; bus.iport_data_i = 0;
        #1 rst = 1;
        #2;
        chk("rst_cyc", bus.iport_cyc_o, 1'b0);
        chk("rst_stb", bus.iport_stb_o, 1'b0);
        chk("rst_addr", bus.iport_address_o, RA);
        chk("rst_idpc", id_pc, RA);
        chk("rst_instr", id_instr, NOP);
        chk("rst_flags", {id_mis, id_flt}, 2'b00);
        chk("rst_busy", busy, 1'b0);
        tick(); tick();
        rst = 0;

        tv[0] = '{1'b0, 1'b0, 1'b1, RA,               RA,               NOP};
        tv[1] = '{1'b1, 1'b0, 1'b1, 32'h8000_0004,    RA,               RA};
        tv[2] = '{1'b1, 1'b0, 1'b1, 32'h8000_0008,    32'h8000_0004,    32'h8000_0004};
        tv[3] = '{1'b1, 1'b0, 1'b1, 32'h8000_000C,    32'h8000_0008,    32'h8000_0008};
        tv[4] = '{1'b1, 1'b1, 1'b0, 32'h0,            32'h8000_0100,    32'h8000_0100};
        tv[5] = '{1'b0, 1'b1, 1'b0, 32'h0,            32'h8000_0100,    32'h8000_0100};
        tv[6] = tv[5];
        tv[7] = tv[5];
        tv[8] = '{1'b0, 1'b0, 1'b1, 32'h8000_0108,    32'h8000_0104,    32'h8000_0104};

        // Sequential fetch with single-cycle ack.
        run_vec(0, 3);

        // Branch while the 0C fetch is outstanding; its late response is discarded.
        bus.iport_ack_i = 0; tb = 1; br_a = 32'h8000_0100;
        #1 chk("br_busy", busy, 1'b1);
        tick(); tb = 0;
        chk("br_hold_addr", bus.iport_address_o, 32'h8000_000C);
        chk("br_bubble", id_instr, NOP);
        tick(); chk("br_wait_addr", bus.iport_address_o, 32'h8000_000C);
        tick(); chk("br_wait_cyc", bus.iport_cyc_o, 1'b1);
        bus.iport_ack_i = 1; bus.iport_data_i = 32'h8000_000C;
        #1 chk("br_ack_busy", busy, 1'b0);
        tick();
        chk("br_new_addr", bus.iport_address_o, 32'h8000_0100);
        chk("br_discard", id_instr, NOP);
        chk("br_discard_pc", id_pc, 32'h8000_0008);
        bus.iport_data_i = bus.iport_address_o;
        tick();
        chk("br_tgt_pc", id_pc, 32'h8000_0100);
        chk("br_tgt_instr", id_instr, 32'h8000_0100);
        chk("br_next_addr", bus.iport_address_o, 32'h8000_0104);

        // Stall with ack in the first stalled cycle, then release.
        run_vec(4, 8);

        // Jump to a misaligned target: no bus cycle, fetch exception.
        bus.iport_ack_i = 1; bus.iport_data_i = bus.iport_address_o;
        tj = 1; jp_a = 32'h8000_0102;
        tick(); tj = 0; bus.iport_ack_i = 0;
        chk("mis_cyc", bus.iport_cyc_o, 1'b0);
        chk("mis_busy", busy, 1'b0);
        chk("mis_bubble", id_instr, NOP);
        tick();
        chk("mis_pc", id_pc, 32'h8000_0102);
        chk("mis_instr", id_instr, NOP);
        chk("mis_flag", {id_mis, id_flt}, 2'b10);

        // Bus error, then exception redirect racing a jump.
        tj = 1; jp_a = 32'h8000_0010;
        tick(); tj = 0;
        chk("err_addr", bus.iport_address_o, 32'h8000_0010);
        chk("err_pre_flag", {id_mis, id_flt}, 2'b00);
        bus.iport_err_i = 1; bus.iport_data_i = 32'hDEAD_BEEF;
        tick(); bus.iport_err_i = 0;
        chk("err_pc", id_pc, 32'h8000_0010);
        chk("err_instr", id_instr, NOP);
        chk("err_flag", {id_mis, id_flt}, 2'b01);
        exc = 1; exc_a = 32'h8000_0200; tj = 1; jp_a = 32'h8000_0300;
        tick(); exc = 0; tj = 0;
        chk("exc_hold_addr", bus.iport_address_o, 32'h8000_0014);
        chk("exc_bubble_flt", id_flt, 1'b0);
        bus.iport_ack_i = 1; bus.iport_data_i = 32'h8000_0014;
        tick();
        chk("exc_addr", bus.iport_address_o, 32'h8000_0200);
        bus.iport_data_i = bus.iport_address_o;
        tick();
        chk("exc_pc", id_pc, 32'h8000_0200);
        chk("exc_instr", id_instr, 32'h8000_0200);

        // Asynchronous reset while a fetch is waiting.
        bus.iport_ack_i = 0;
        #2 rst = 1;
        #1;
        chk("arst_cyc", bus.iport_cyc_o, 1'b0);
        chk("arst_addr", bus.iport_address_o, RA);
        chk("arst_idpc", id_pc, RA);
        chk("arst_instr", id_instr, NOP);
        bus.iport_ack_i = 1; bus.iport_data_i = 32'h1234_5678;
        tick(); tick();
        rst = 0;
        tick();
        chk("arst_restart_addr", bus.iport_address_o, RA);
        chk("arst_late_ack", id_instr, NOP);
        bus.iport_data_i = bus.iport_address_o;
        tick();
        chk("arst_first_pc", id_pc, RA);
        chk("arst_first_instr", id_instr, RA);

        // Sequential PC wraps at the top of the address space.
        exc = 1; exc_a = 32'hFFFF_FFFC; bus.iport_data_i = bus.iport_address_o;
        tick(); exc = 0;
        chk("wrap_top", bus.iport_address_o, 32'hFFFF_FFFC);
        bus.iport_data_i = bus.iport_address_o;
        tick();
        chk("wrap_zero", bus.iport_address_o, 32'h0);
        chk("wrap_pc", id_pc, 32'hFFFF_FFFC);

        // Random ack latency, bus errors and decode stalls against the scoreboard.
        bus.iport_ack_i = 0;
        rst = 1; tick(); rst = 0;
        req_act = 0; lat = 0; exp_fa = RA; have_last = 0; last_pc = 0;
        p_pc = id_pc; p_instr = id_instr;
        for (int c = 0; c < 1500; c++) begin
            st = (c < 1497) ? ($urandom_range(0, 3) == 0) : 1'b0;
            bus.iport_ack_i = 0; bus.iport_err_i = 0;
            if (bus.iport_cyc_o) begin
                if (!req_act) begin
                    req_act = 1; lat = $urandom_range(0, 3); req_addr = bus.iport_address_o;
                end else begin
                    chk("addr_stable", bus.iport_address_o, req_addr);
                end
                if (lat == 0 && c < 1497) begin
                    chk("fetch_addr", bus.iport_address_o, exp_fa);
                    e = ($urandom_range(0, 7) == 0);
                    bus.iport_err_i  = e;
                    bus.iport_ack_i  = !e;
                    bus.iport_data_i = ~bus.iport_address_o;
                    d.pc = exp_fa; d.instr = e ? NOP : ~exp_fa; d.flt = e;
                    q.push_back(d);
                    exp_fa += 32'd4; req_act = 0;
                end else if (lat > 0) begin
                    lat--;
                end
            end
            stall = st;
            tick();
            observe(st);
            p_pc = id_pc; p_instr = id_instr;
        end
        chk("queue_drained", q.size(), 0);
        chk("progress", (ndel > 200) ? 1 : 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
